calc1_port_scheduler: RTL
=========================

Name: calc1_port_scheduler

Overview:
- Front-end scheduler for the calc1 design. It accepts two-cycle command transactions on four requester ports and shares one execution unit (ALU) between them.
- Arbitration is round-robin. The scheduler issues one operation at a time and routes each result back to the port that issued it.
- Invalid commands and ALU timeouts are answered locally, without using the ALU.

Parameters:
- TIMEOUT, default 255: cycles in ARB_WAIT with no alu_done before the scheduler forces an internal-error response.
- TO_WIDTH, default 8: timeout counter width; must satisfy 2^TO_WIDTH > TIMEOUT.

Ports:
- c_clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- reqN_cmd_in  in  [0:3]  command for port N (N=1..4); 0=none, 1=add, 2=sub, 5=shl, 6=shr.
- reqN_data_in  in  [0:31]  operand 1 in the cmd cycle, operand 2 in the next cycle.
- out_respN  out  [0:1]  0=none, 1=success, 2=overflow/underflow/invalid cmd, 3=internal error (timeout).
- out_dataN  out  [0:31]  result; valid only while out_respN=1.
- alu_valid  out  1  one-cycle issue pulse.
- alu_cmd  out  [0:3]  command of the granted transaction; stable from issue until alu_done.
- alu_op1, alu_op2  out  [0:31]  operands; stable from issue until alu_done.
- alu_done  in  1  one-cycle completion pulse.
- alu_resp  in  [0:1]  ALU response, sampled on alu_done.
- alu_data  in  [0:31]  ALU result, sampled on alu_done.

Behaviour:
- Reset (reset=0, asynchronous):
  - All out_respN, out_dataN, alu_valid, alu_cmd, alu_op1, alu_op2 go to 0.
  - All ports go to P_IDLE, the arbiter goes to ARB_IDLE, the round-robin pointer goes to port 1, the timeout counter goes to 0.
  - Reset mid-transaction abandons it with no response.
- Per-port capture FSM (P_IDLE -> P_OP2 -> P_PEND -> P_IDLE):
  - P_IDLE: on an edge where cmd!=0, latch cmd and data as op1, then go to P_OP2. cmd=0 means stay.
  - P_OP2: latch data as op2 unconditionally. A cmd value in this cycle is ignored. Then:
    - cmd in {1,2,5,6}: go to P_PEND.
    - any other cmd: go to P_IDLE and register out_respN=2, out_dataN=0 for exactly one cycle; the ALU is never used.
  - P_PEND: all cmd inputs on this port are ignored. The port waits for a grant and then for its result.
  - Return to P_IDLE happens on the same edge that registers out_respN!=0. A cmd presented during the cycle out_respN is visible is accepted.
- Arbiter FSM:
  - ARB_IDLE: if any port is in P_PEND, grant the first pending port at or after the pointer (wrap 4->1). On that edge, drive alu_valid=1 with the port's cmd/op1/op2, move the pointer to granted+1 (4 wraps to 1), and go to ARB_WAIT.
  - ARB_WAIT: alu_valid=0; alu_cmd/op1/op2 hold their values; the timeout counter increments each cycle.
  - alu_done in ARB_WAIT: on that edge, register out_respN=alu_resp for the granted port. out_dataN=alu_data if alu_resp=1, else 0. Go to ARB_IDLE.
  - No alu_done after TIMEOUT cycles: register out_respN=3, out_dataN=0 for the granted port and go to ARB_IDLE.
  - In both exits, clear the counter.
  - alu_done outside ARB_WAIT is ignored.
- Issue latency: minimum issue is the edge after op2 capture. The earliest response is one edge after alu_done.
- Responses last exactly one cycle; otherwise outputs are 0.
- Responses to different ports may coincide (invalid-cmd reply on one port plus ALU reply on another); both are driven.
- No data arithmetic is done in this block; operands pass through unmodified.

Test Plan:
1. Single add on port 1: cmd=1, data=255, then data=1; ALU model returns resp=1, data=256 after 3 cycles -> alu_valid pulses once with op1=255, op2=1; out_resp1=1, out_data1=256 for one cycle; other ports 0.
2. All four ports issue cmd=2 in the same cycle; ALU latency 1 -> grants in order 1,2,3,4. A second round, issued by all ports right after their responses, is granted in the order 1,2,3,4 again (pointer wrapped to 1).
3. Invalid command: port 3 cmd=4 -> alu_valid never asserts; out_resp3=2, out_data3=0, two edges after cmd.
4. Timeout with TIMEOUT=4: ALU never asserts alu_done -> out_resp2=3 for one cycle, 5 cycles after issue. A following port-1 request is then served normally.
5. Reset asserted while in ARB_WAIT with port 4 pending -> all outputs 0 immediately (before the next edge); no response on port 4 after release; a fresh port-4 request completes with resp=1.
6. Port 1 issues a new cmd=5 during its response cycle, and a spurious alu_done arrives in ARB_IDLE -> the new cmd is accepted and served; the spurious done produces no response.

Source files
------------

// File: rtl/calc1_port_scheduler.sv
// calc1 front-end: four two-cycle command ports share one ALU through a round-robin arbiter.
// Invalid commands and ALU timeouts are answered locally without touching the ALU.
module calc1_port_scheduler #(
    parameter int TIMEOUT  = 255,
    parameter int TO_WIDTH = 8
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  req1_cmd_in,
    input  logic [3:0]  req2_cmd_in,
    input  logic [3:0]  req3_cmd_in,
    input  logic [3:0]  req4_cmd_in,
    input  logic [31:0] req1_data_in,
    input  logic [31:0] req2_data_in,
    input  logic [31:0] req3_data_in,
    input  logic [31:0] req4_data_in,
    output logic [1:0]  out_resp1,
    output logic [1:0]  out_resp2,
    output logic [1:0]  out_resp3,
    output logic [1:0]  out_resp4,
    output logic [31:0] out_data1,
    output logic [31:0] out_data2,
    output logic [31:0] out_data3,
    output logic [31:0] out_data4,
    output logic        alu_valid,
    output logic [3:0]  alu_cmd,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    input  logic        alu_done,
    input  logic [1:0]  alu_resp,
    input  logic [31:0] alu_data
);
    typedef enum logic [1:0] {P_IDLE, P_OP2, P_PEND} port_state_t;
    typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;

    logic [3:0]  cmd_in   [4];
    logic [31:0] data_in  [4];
    logic [1:0]  resp_out [4];
    logic [31:0] data_out [4];
    logic [3:0]  port_cmd [4];
    logic [31:0] port_op1 [4];
    logic [31:0] port_op2 [4];
    logic [3:0]  pending;

    assign cmd_in[0]  = req1_cmd_in;
    assign cmd_in[1]  = req2_cmd_in;
    assign cmd_in[2]  = req3_cmd_in;
    assign cmd_in[3]  = req4_cmd_in;
    assign data_in[0] = req1_data_in;
    assign data_in[1] = req2_data_in;
    assign data_in[2] = req3_data_in;
    assign data_in[3] = req4_data_in;
    assign out_resp1  = resp_out[0];
    assign out_resp2  = resp_out[1];
    assign out_resp3  = resp_out[2];
    assign out_resp4  = resp_out[3];
    assign out_data1  = data_out[0];
    assign out_data2  = data_out[1];
    assign out_data3  = data_out[2];
    assign out_data4  = data_out[3];

    arb_state_t          arb_state_reg, arb_state_next;
    logic [1:0]          grant_reg, grant_next;
    logic [1:0]          ptr_reg, ptr_next;
    logic [TO_WIDTH-1:0] cnt_reg, cnt_next;
    logic                alu_valid_next;
    logic [3:0]          alu_cmd_next;
    logic [31:0]         alu_op1_next, alu_op2_next;
    logic [1:0]          sel;
    logic                sel_found;
    logic                finish;
    logic [1:0]          finish_resp;
    logic [31:0]         finish_data;

    // A transaction ends on alu_done; the timeout only fires when done is absent.
    always_comb begin
        finish      = 1'b0;
        finish_resp = 2'd0;
        finish_data = '0;
        if (arb_state_reg == ARB_WAIT) begin
            if (alu_done) begin
                finish      = 1'b1;
                finish_resp = alu_resp;
                finish_data = (alu_resp == 2'd1) ? alu_data : '0;
            end else if (cnt_reg == TO_WIDTH'(TIMEOUT)) begin
                finish      = 1'b1;
                finish_resp = 2'd3;
            end
        end
    end

    // First pending port at or after the pointer; 2-bit index wraps 4 -> 1.
    always_comb begin
        sel       = ptr_reg;
        sel_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!sel_found && pending[ptr_reg + 2'(k)]) begin
                sel       = ptr_reg + 2'(k);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        arb_state_next = arb_state_reg;
        grant_next     = grant_reg;
        ptr_next       = ptr_reg;
        cnt_next       = cnt_reg;
        alu_valid_next = 1'b0;
        alu_cmd_next   = alu_cmd;
        alu_op1_next   = alu_op1;
        alu_op2_next   = alu_op2;
        case (arb_state_reg)
            ARB_IDLE: begin
                if (sel_found) begin
                    grant_next     = sel;
                    ptr_next       = sel + 2'd1;
                    alu_valid_next = 1'b1;
                    alu_cmd_next   = port_cmd[sel];
                    alu_op1_next   = port_op1[sel];
                    alu_op2_next   = port_op2[sel];
                    arb_state_next = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (finish) begin
                    cnt_next       = '0;
                    arb_state_next = ARB_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: arb_state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            arb_state_reg <= ARB_IDLE;
            grant_reg     <= 2'd0;
            ptr_reg       <= 2'd0;
            cnt_reg       <= '0;
            alu_valid     <= 1'b0;
            alu_cmd       <= 4'd0;
            alu_op1       <= 32'd0;
            alu_op2       <= 32'd0;
        end else begin
            arb_state_reg <= arb_state_next;
            grant_reg     <= grant_next;
            ptr_reg       <= ptr_next;
            cnt_reg       <= cnt_next;
            alu_valid     <= alu_valid_next;
            alu_cmd       <= alu_cmd_next;
            alu_op1       <= alu_op1_next;
            alu_op2       <= alu_op2_next;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_port
        port_state_t state_reg, state_next;
        logic [3:0]  cmd_reg, cmd_next;
        logic [31:0] op1_reg, op1_next, op2_reg, op2_next;
        logic [1:0]  resp_reg, resp_next;
        logic [31:0] dout_reg, dout_next;
        logic        granted_done;

        assign granted_done   = finish && (grant_reg == 2'(gi));
        assign pending[gi]    = (state_reg == P_PEND);
        assign port_cmd[gi]   = cmd_reg;
        assign port_op1[gi]   = op1_reg;
        assign port_op2[gi]   = op2_reg;
        assign resp_out[gi]   = resp_reg;
        assign data_out[gi]   = dout_reg;

        always_comb begin
            state_next = state_reg;
            cmd_next   = cmd_reg;
            op1_next   = op1_reg;
            op2_next   = op2_reg;
            resp_next  = 2'd0;
            dout_next  = 32'd0;
            case (state_reg)
                P_IDLE: begin
                    if (cmd_in[gi] != 4'd0) begin
                        cmd_next   = cmd_in[gi];
                        op1_next   = data_in[gi];
                        state_next = P_OP2;
                    end
                end
                P_OP2: begin
                    op2_next = data_in[gi];
                    if (cmd_reg inside {4'd1, 4'd2, 4'd5, 4'd6}) begin
                        state_next = P_PEND;
                    end else begin
                        state_next = P_IDLE;
                        resp_next  = 2'd2;
                    end
                end
                P_PEND: begin
                    if (granted_done) begin
                        state_next = P_IDLE;
                        resp_next  = finish_resp;
                        dout_next  = finish_data;
                    end
                end
                default: state_next = P_IDLE;
            endcase
        end

        always_ff @(posedge c_clk or negedge reset) begin
            if (!reset) begin
                state_reg <= P_IDLE;
                cmd_reg   <= 4'd0;
                op1_reg   <= 32'd0;
                op2_reg   <= 32'd0;
                resp_reg  <= 2'd0;
                dout_reg  <= 32'd0;
            end else begin
                state_reg <= state_next;
                cmd_reg   <= cmd_next;
                op1_reg   <= op1_next;
                op2_reg   <= op2_next;
                resp_reg  <= resp_next;
                dout_reg  <= dout_next;
            end
        end
    end
endmodule
